// File: rtl/mdu_pipe.sv
// Multiply/divide unit with HI/LO registers: mult, div, multiply-accumulate, mthi/mtlo.
// Long ops hold busy for a fixed cycle count and commit HI/LO on the edge busy falls.
module mdu_pipe #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDU_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             div_zero
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_TERM = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_TERM  = CW'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;

    logic             accept;
    logic             op_is_div;
    logic [CW-1:0]    term;

    logic [2*WIDTH-1:0] sa, sb, ua, ub, prod_s, prod_u, acc;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, dvsr, uq, ur, q_out, r_out;
    logic [WIDTH-1:0]   hi_d, lo_d;

    assign accept    = start && !busy_q && !flush && (MDU_op >= OP_MULT) && (MDU_op <= OP_MSUBU);
    assign op_is_div = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
    assign term      = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? DIV_TERM : MULT_TERM;

    // Products are formed at 2*WIDTH so the truncated result is the exact signed/unsigned product.
    assign sa     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign sb     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign ua     = {{WIDTH{1'b0}}, a_q};
    assign ub     = {{WIDTH{1'b0}}, b_q};
    assign prod_s = sa * sb;
    assign prod_u = ua * ub;
    assign acc    = {hi_q, lo_q};

    // Signed divide via magnitudes; most-negative / -1 naturally yields LO=A, HI=0.
    assign neg_a = (op_q == OP_DIV) && a_q[WIDTH-1];
    assign neg_b = (op_q == OP_DIV) && b_q[WIDTH-1];
    assign mag_a = neg_a ? (~a_q + WIDTH'(1)) : a_q;
    assign mag_b = neg_b ? (~b_q + WIDTH'(1)) : b_q;
    assign dvsr  = (mag_b == '0) ? WIDTH'(1) : mag_b;
    assign uq    = mag_a / dvsr;
    assign ur    = mag_a % dvsr;
    assign q_out = (neg_a ^ neg_b) ? (~uq + WIDTH'(1)) : uq;
    assign r_out = neg_a ? (~ur + WIDTH'(1)) : ur;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_MADD:  {hi_d, lo_d} = acc + prod_s;
            OP_MADDU: {hi_d, lo_d} = acc + prod_u;
            OP_MSUB:  {hi_d, lo_d} = acc - prod_s;
            OP_MSUBU: {hi_d, lo_d} = acc - prod_u;
            OP_DIV, OP_DIVU: begin
                if (b_q != '0) begin
                    hi_d = r_out;
                    lo_d = q_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q  <= A;
                        b_q  <= B;
                        op_q <= MDU_op;
                        case (MDU_op)
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: begin
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                                cnt_q   <= CW'(1);
                                if (op_is_div && (B == '0)) div_zero_q <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == term) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_pipe.sv
// Directed and random scenarios for mdu_pipe at WIDTH=32 with default cycle counts.
module tb_mdu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDU_op;
    logic [31:0] A, B;
    logic        flush;
    logic        busy;
    logic [31:0] HI, LO;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb_q[$];
    logic [31:0] sh_hi = '0, sh_lo = '0;

    mdu_pipe #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDU_op(MDU_op), .A(A), .B(B),
        .flush(flush), .busy(busy), .HI(HI), .LO(LO), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        longint          sp;
        longint unsigned up;
        logic [63:0]     acc;
        int              si, sj;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'b0, a} * {32'b0, b};
        acc = {hi, lo};
        si  = a;
        sj  = b;
        case (op)
            4'd1:  return sp;
            4'd2:  return up;
            4'd3: begin
                if (b == 0) return acc;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                return {32'(si % sj), 32'(si / sj)};
            end
            4'd4:  return (b == 0) ? acc : {a % b, a / b};
            4'd5:  return {a, lo};
            4'd6:  return {hi, a};
            4'd7:  return acc + sp;
            4'd8:  return acc + up;
            4'd9:  return acc - sp;
            4'd10: return acc - up;
            default: return acc;
        endcase
    endfunction

    function automatic int exp_cyc(input logic [3:0] op);
        if (op == 4'd3 || op == 4'd4) return 10;
        if (op == 4'd1 || op == 4'd2 || (op >= 4'd7 && op <= 4'd10)) return 5;
        return 0;
    endfunction

    // Issues one op from IDLE, scrambles inputs after acceptance, and counts busy cycles.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        logic [63:0] e;
        @(negedge clk);
        start = 1'b1; MDU_op = op; A = a; B = b;
        e = model(op, a, b, sh_hi, sh_lo);
        sb_q.push_back(e);
        {sh_hi, sh_lo} = e;
        @(posedge clk); #1;
        start = 1'b0; MDU_op = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; MDU_op = '0; A = '0; B = '0; flush = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h want=0", HI); end
        checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h want=0", LO); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b want=0", div_zero); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_mult;
        int c; logic [63:0] e;
        do_op(4'd1, 32'hFFFF_FFFE, 32'd3, c);
        checks++; if (c !== 5) begin errors++; $display("FAIL mult_lat got=%0d want=5", c); end
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mult got=%h want=%h", {HI, LO}, e); end
        do_op(4'd2, 32'hFFFF_FFFE, 32'd3, c);
        checks++; if (c !== 5) begin errors++; $display("FAIL multu_lat got=%0d want=5", c); end
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL multu got=%h want=%h", {HI, LO}, e); end
    endtask

    task automatic test_div;
        int c; logic [63:0] e;
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL div_lat got=%0d want=10", c); end
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL div got=%h want=%h", {HI, LO}, e); end
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, c);
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL div_ovf got=%h want=%h", {HI, LO}, e); end
    endtask

    task automatic test_madd;
        int c; logic [63:0] e;
        do_op(4'd5, 32'h0000_1234, 32'd0, c);
        checks++; if (c !== 0) begin errors++; $display("FAIL mthi_busy got=%0d want=0", c); end
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mthi got=%h want=%h", {HI, LO}, e); end
        do_op(4'd6, 32'hFFFF_FFFF, 32'd0, c);
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mtlo got=%h want=%h", {HI, LO}, e); end
        do_op(4'd7, 32'd2, 32'd3, c);
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL madd got=%h want=%h", {HI, LO}, e); end
    endtask

    task automatic test_div_zero;
        int c; logic [63:0] e;
        do_op(4'd4, 32'd99, 32'd0, c);
        checks++; if (c !== 10) begin errors++; $display("FAIL dz_lat got=%0d want=10", c); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", div_zero); end
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL dz_hilo got=%h want=%h", {HI, LO}, e); end
    endtask

    task automatic test_busy_ignore;
        int c; logic [63:0] e;
        @(negedge clk);
        start = 1'b1; MDU_op = 4'd1; A = 32'd7; B = 32'd6;
        e = model(4'd1, 32'd7, 32'd6, sh_hi, sh_lo);
        sb_q.push_back(e);
        {sh_hi, sh_lo} = e;
        @(posedge clk); #1;
        MDU_op = 4'd5; A = 32'hDEAD; B = 32'd0;
        c = 0;
        while (busy && c < 200) begin
            c++;
            if (c == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (c !== 5) begin errors++; $display("FAIL ign_lat got=%0d want=5", c); end
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL ign_res got=%h want=%h", {HI, LO}, e); end
    endtask

    task automatic test_flush;
        @(negedge clk);
        start = 1'b1; MDU_op = 4'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
        checks++; if ({HI, LO} !== {sh_hi, sh_lo}) begin errors++; $display("FAIL flush_hilo got=%h want=%h", {HI, LO}, {sh_hi, sh_lo}); end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; MDU_op = 4'd5; A = 32'hBEEF;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        checks++; if ({busy, HI} !== {1'b0, sh_hi}) begin errors++; $display("FAIL flush_start got=%b/%h want=0/%h", busy, HI, sh_hi); end
    endtask

    task automatic test_flush_final;
        int c; logic [63:0] e;
        @(negedge clk);
        start = 1'b1; MDU_op = 4'd4; A = 32'd1000; B = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ffin_pre got=%b want=1", busy); end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checks++; if (busy !== 1'b0 || {HI, LO} !== {sh_hi, sh_lo}) begin
            errors++; $display("FAIL ffin got=%b/%h want=0/%h", busy, {HI, LO}, {sh_hi, sh_lo});
        end
        do_op(4'd4, 32'd1000, 32'd3, c);
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL ffin_next got=%h want=%h", {HI, LO}, e); end
    endtask

    task automatic test_reset_mid;
        int c; logic [63:0] e;
        @(negedge clk);
        start = 1'b1; MDU_op = 4'd1; A = 32'd5; B = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; #1;
        checks++; if ({busy, div_zero, HI, LO} !== 66'h0) begin
            errors++; $display("FAIL rst_mid got=%b%b/%h/%h want=all0", busy, div_zero, HI, LO);
        end
        sh_hi = '0; sh_lo = '0;
        @(negedge clk);
        reset = 1'b0; start = 1'b1; MDU_op = 4'd1; A = 32'hFFFF_FFFD; B = 32'd4;
        e = model(4'd1, 32'hFFFF_FFFD, 32'd4, sh_hi, sh_lo);
        sb_q.push_back(e);
        {sh_hi, sh_lo} = e;
        @(posedge clk); #1; start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_first got=%b want=1", busy); end
        c = 0;
        while (busy && c < 200) begin c++; @(posedge clk); #1; end
        checks++; if (c !== 5) begin errors++; $display("FAIL rst_lat got=%0d want=5", c); end
        e = sb_q.pop_front();
        checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL rst_res got=%h want=%h", {HI, LO}, e); end
    endtask

    task automatic test_back_to_back;
        int c; logic [63:0] e; logic [3:0] op; logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom);
            do_op(op, a, b, c);
            checks++; if (c !== exp_cyc(op)) begin errors++; $display("FAIL b2b_lat op=%0d got=%0d want=%0d", op, c, exp_cyc(op)); end
            e = sb_q.pop_front();
            checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL b2b op=%0d got=%h want=%h", op, {HI, LO}, e); end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_madd;
        test_div_zero;
        test_busy_ignore;
        test_flush;
        test_flush_final;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
